// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter.
// Frame format: start bit, 8 data bits LSB first, even parity bit, stop bit.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 864,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [7:0]      din,
    input  logic            din_valid,
    output logic            Tx_D,
    output logic            tx_busy,
    output logic            fifo_empty,
    output logic            fifo_full,
    output logic [ADDR_W:0] fifo_count,
    output logic            overflow
);
    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [ADDR_W:0]   PTR_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic              r_tx_d;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [2:0]        r_bit_idx;
    logic [BAUD_W-1:0] r_baud;

    logic [ADDR_W:0]   w_wr_ptr_nxt;
    logic [ADDR_W:0]   w_rd_ptr_nxt;
    logic [7:0]        w_head;
    logic              w_wr_en;
    logic              w_pop;
    logic              w_baud_done;
    logic              w_tx_d_nxt;
    logic              w_busy;

    // A full FIFO drops the incoming byte even when a pop frees a slot this cycle.
    assign w_wr_en      = din_valid && !r_full;
    assign w_wr_ptr_nxt = w_wr_en ? r_wr_ptr + PTR_ONE : r_wr_ptr;
    assign w_rd_ptr_nxt = w_pop   ? r_rd_ptr + PTR_ONE : r_rd_ptr;
    assign w_head       = r_mem[r_rd_ptr[ADDR_W-1:0]];
    assign w_baud_done  = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_wr_ptr_nxt - w_rd_ptr_nxt;
            r_empty    <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
            r_full     <= (w_wr_ptr_nxt[ADDR_W] != w_rd_ptr_nxt[ADDR_W]) &&
                          (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);
            r_overflow <= r_overflow || (din_valid && r_full);
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: default assignment first so no path through the case can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (!r_empty)                        w_state_nxt = S_START;
            S_START:  if (w_baud_done)                     w_state_nxt = S_DATA;
            S_DATA:   if (w_baud_done && r_bit_idx == 3'd7) w_state_nxt = S_PARITY;
            S_PARITY: if (w_baud_done)                     w_state_nxt = S_STOP;
            S_STOP:   if (w_baud_done)                     w_state_nxt = S_IDLE;
            default:                                       w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop      = 1'b0;
        w_busy     = 1'b1;
        w_tx_d_nxt = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_pop  = !r_empty;
                w_busy = !r_empty;
            end
            S_START:  w_tx_d_nxt = 1'b0;
            S_DATA:   w_tx_d_nxt = r_shift[r_bit_idx];
            S_PARITY: w_tx_d_nxt = r_parity;
            S_STOP:   w_tx_d_nxt = 1'b1;
            default:  w_busy     = 1'b0;
        endcase
    end

    // The line driver is registered, so Tx_D trails the state by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_d    <= 1'b1;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_idx <= '0;
            r_baud    <= '0;
        end else begin
            r_tx_d <= w_tx_d_nxt;
            if (w_pop) begin
                r_shift  <= w_head;
                r_parity <= ^w_head;
            end
            if (r_state == S_IDLE || w_baud_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + BAUD_ONE;
            end
            if (r_state == S_IDLE) begin
                r_bit_idx <= '0;
            end else if (r_state == S_DATA && w_baud_done) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    assign Tx_D       = r_tx_d;
    assign tx_busy    = w_busy;
    assign fifo_empty = r_empty;
    assign fifo_full  = r_full;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame table, latency, fill/overflow,
// pointer wrap, write-during-pop and mid-frame reset.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    din = '0;
    logic          din_valid = 1'b0;
    logic          Tx_D;
    logic          tx_busy;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    logic          overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit wrap_done;

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;

    vec_t vecs [7];

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_W       (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .Tx_D       (Tx_D),
        .tx_busy    (tx_busy),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ^b, b, 1'b0};
    endfunction

    task automatic do_reset();
        din_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Called on a negedge; the byte is taken at the following posedge.
    task automatic write_byte(input logic [7:0] b);
        din = b;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // Waits (bounded) for a start bit, then samples each bit 1.5 cycles into it.
    task automatic recv_frame(output logic [10:0] f, output int t_start, output logic seen);
        int waited = 0;
        f = '1;
        t_start = 0;
        seen = 1'b0;
        while (!seen && waited < 400) begin
            @(negedge clk);
            waited++;
            if (Tx_D === 1'b0) seen = 1'b1;
        end
        if (seen) begin
            t_start = cyc;
            @(negedge clk);
            f[0] = Tx_D;
            for (int i = 1; i < 11; i++) begin
                repeat (CPB) @(negedge clk);
                f[i] = Tx_D;
            end
        end
    endtask

    initial begin
        logic [10:0] f;
        logic [10:0] fr;
        logic [43:0] got_bits;
        logic [43:0] exp_bits;
        logic        seen;
        int          t_a;
        int          t_b;
        int          busy_cnt;
        int          low_cnt;
        int          max_cnt;
        int          ovf_seen;

        vecs[0] = '{8'hA5, 11'h54A};
        vecs[1] = '{8'h00, 11'h400};
        vecs[2] = '{8'hFF, 11'h5FE};
        vecs[3] = '{8'h01, 11'h602};
        vecs[4] = '{8'h80, 11'h700};
        vecs[5] = '{8'h3C, 11'h478};
        vecs[6] = '{8'h57, 11'h6AE};

        // Reset state
        do_reset();
        check("rst_tx_d",     Tx_D,       1);
        check("rst_busy",     tx_busy,    0);
        check("rst_empty",    fifo_empty, 1);
        check("rst_full",     fifo_full,  0);
        check("rst_count",    fifo_count, 0);
        check("rst_overflow", overflow,   0);

        // Single byte 0xA5: latency, bit pattern, busy duration
        repeat (2) @(negedge clk);
        write_byte(8'hA5);
        check("sb_empty_after_wr", fifo_empty, 0);
        check("sb_count_after_wr", fifo_count, 1);
        check("sb_busy_pop_cycle", tx_busy,    1);
        check("sb_tx_pop_cycle",   Tx_D,       1);
        busy_cnt = int'(tx_busy);
        @(negedge clk);
        check("sb_tx_still_high",  Tx_D,       1);
        check("sb_count_popped",   fifo_count, 0);
        busy_cnt += int'(tx_busy);
        fr = 11'h54A;
        for (int i = 0; i < 44; i++) begin
            @(negedge clk);
            got_bits[i] = Tx_D;
            exp_bits[i] = fr[i / CPB];
            busy_cnt += int'(tx_busy);
        end
        check("sb_serial_bits", got_bits, exp_bits);
        low_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            busy_cnt += int'(tx_busy);
            if (Tx_D !== 1'b1) low_cnt++;
        end
        check("sb_busy_cycles", busy_cnt, 45);
        check("sb_idle_after",  low_cnt,  0);

        // Frame table
        for (int v = 0; v < 7; v++) begin
            write_byte(vecs[v].data);
            recv_frame(f, t_a, seen);
            check($sformatf("tbl%0d_start_seen", v), seen, 1);
            check($sformatf("tbl%0d_frame", v), f, vecs[v].frame);
        end
        repeat (10) @(negedge clk);

        // Fill and overflow while the transmitter is busy with a filler byte
        fork
            begin
                write_byte(8'hFF);
                @(negedge clk);
                for (int i = 0; i < 17; i++) begin
                    din = 8'(i);
                    din_valid = 1'b1;
                    @(negedge clk);
                    if (i == 15) begin
                        check("fill_full_16",     fifo_full,  1);
                        check("fill_count_16",    fifo_count, 16);
                        check("fill_overflow_16", overflow,   0);
                    end
                end
                din_valid = 1'b0;
                check("fill_overflow_17", overflow,   1);
                check("fill_count_17",    fifo_count, 16);
            end
            begin
                for (int i = 0; i < 17; i++) begin
                    recv_frame(f, t_a, seen);
                    check($sformatf("fill%0d_start_seen", i), seen, 1);
                    check($sformatf("fill%0d_frame", i), f,
                          frame_of((i == 0) ? 8'hFF : 8'(i - 1)));
                end
            end
        join
        low_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (Tx_D !== 1'b1) low_cnt++;
        end
        check("fill_no_extra_frame", low_cnt,    0);
        check("fill_drained_empty",  fifo_empty, 1);
        check("fill_overflow_stick", overflow,   1);

        // Pointer wrap: 40 bytes paced at one per 46 cycles
        do_reset();
        check("wrap_overflow_cleared", overflow, 0);
        wrap_done = 1'b0;
        max_cnt = 0;
        ovf_seen = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    write_byte(8'(i));
                    repeat (45) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    recv_frame(f, t_a, seen);
                    check($sformatf("wrap%0d_start_seen", i), seen, 1);
                    check($sformatf("wrap%0d_frame", i), f, frame_of(8'(i)));
                end
                wrap_done = 1'b1;
            end
            begin
                while (!wrap_done) begin
                    @(negedge clk);
                    if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
                    if (overflow) ovf_seen = 1;
                end
            end
        join
        check("wrap_max_count", max_cnt,  1);
        check("wrap_overflow",  ovf_seen, 0);

        // Write in the pop cycle: count holds at 1, second byte follows with a 1-cycle gap
        do_reset();
        write_byte(8'h3C);
        write_byte(8'hC3);
        check("simul_count", fifo_count, 1);
        check("simul_overflow", overflow, 0);
        recv_frame(f, t_a, seen);
        check("simul_a_seen",  seen, 1);
        check("simul_a_frame", f, frame_of(8'h3C));
        recv_frame(f, t_b, seen);
        check("simul_b_seen",  seen, 1);
        check("simul_b_frame", f, frame_of(8'hC3));
        check("simul_spacing", t_b - t_a, 11 * CPB + 1);

        // Reset during DATA bit 3 with 5 bytes queued
        repeat (10) @(negedge clk);
        for (int i = 0; i < 6; i++) write_byte(8'(i * 16));
        check("mid_count_queued", fifo_count, 5);
        repeat (14) @(negedge clk);
        check("mid_tx_d3_low", Tx_D,    0);
        check("mid_busy",      tx_busy, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_tx_d",  Tx_D,       1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy",  tx_busy,    0);
        check("mid_rst_empty", fifo_empty, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        low_cnt = 0;
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (Tx_D !== 1'b1) low_cnt++;
            busy_cnt += int'(tx_busy);
        end
        check("mid_post_idle_line", low_cnt,    0);
        check("mid_post_busy",      busy_cnt,   0);
        check("mid_post_count",     fifo_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
